alu_result_stage: RTL and testbench

//  Pipeline register stage directly downstream of the ALU. It captures opcode, result and the

---
 rtl/alu_result_stage.sv | 146 ++++++++++++++
 tb/tb_alu_result_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result pipeline stage.
// Captures the ALU output bundle (opcode, result, flags) behind a valid/ready
// handshake using a two-entry main+skid buffer, so in_ready depends only on
// registered state. Also maintains the architectural flag register, a sticky
// overflow bit and a saturating overflow-event counter, all updated in issue
// order (on acceptance, not on delivery).
module alu_result_stage #(
  parameter int BUS_WIDTH     = 32,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [BUS_WIDTH-1:0]     in_result,
  input  logic [3:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_opcode,
  output logic [BUS_WIDTH-1:0]     out_result,
  output logic [3:0]               out_flags,
  output logic [3:0]               flags_q,
  output logic                     ovf_sticky,
  input  logic                     sticky_clr,
  output logic [OVF_CNT_WIDTH-1:0] ovf_count
);

  localparam logic [3:0]               OP_NUL  = 4'b0000;
  localparam logic [OVF_CNT_WIDTH-1:0] CNT_ONE = OVF_CNT_WIDTH'(1);

  // Buffer occupancy and entry contents
  logic                     r_main_v;
  logic                     r_skid_v;
  logic [3:0]               r_main_op;
  logic [BUS_WIDTH-1:0]     r_main_res;
  logic [3:0]               r_main_flg;
  logic [3:0]               r_skid_op;
  logic [BUS_WIDTH-1:0]     r_skid_res;
  logic [3:0]               r_skid_flg;

  // Status registers
  logic [3:0]               r_flags_q;
  logic                     r_ovf_sticky;
  logic [OVF_CNT_WIDTH-1:0] r_ovf_count;

  logic w_in_fire;
  logic w_out_fire;
  logic w_in_ovf;
  logic w_cnt_max;

  // in_ready comes straight from the skid valid register, never from out_ready.
  assign w_in_fire  = in_valid & ~r_skid_v;
  assign w_out_fire = r_main_v & out_ready;
  assign w_in_ovf   = w_in_fire & in_flags[3];
  assign w_cnt_max  = &r_ovf_count;

  assign in_ready   = ~r_skid_v;
  assign out_valid  = r_main_v;
  assign out_opcode = r_main_op;
  assign out_result = r_main_res;
  assign out_flags  = r_main_flg;
  assign flags_q    = r_flags_q;
  assign ovf_sticky = r_ovf_sticky;
  assign ovf_count  = r_ovf_count;

  // Skid-buffer datapath: EMPTY(0,0) / ONE(1,0) / FULL(1,1); data loads only on fire so X inputs never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_main_op  <= 4'b0000;
      r_main_res <= '0;
      r_main_flg <= 4'b0000;
      r_skid_op  <= 4'b0000;
      r_skid_res <= '0;
      r_skid_flg <= 4'b0000;
    end else begin
      case ({r_main_v, r_skid_v})
        2'b00: begin
          if (w_in_fire) begin
            r_main_v   <= 1'b1;
            r_main_op  <= in_opcode;
            r_main_res <= in_result;
            r_main_flg <= in_flags;
          end
        end
        2'b10: begin
          if (w_in_fire && w_out_fire) begin
            r_main_op  <= in_opcode;
            r_main_res <= in_result;
            r_main_flg <= in_flags;
          end else if (w_in_fire) begin
            r_skid_v   <= 1'b1;
            r_skid_op  <= in_opcode;
            r_skid_res <= in_result;
            r_skid_flg <= in_flags;
          end else if (w_out_fire) begin
            r_main_v   <= 1'b0;
          end
        end
        2'b11: begin
          if (w_out_fire) begin
            r_main_op  <= r_skid_op;
            r_main_res <= r_skid_res;
            r_main_flg <= r_skid_flg;
            r_skid_v   <= 1'b0;
          end
        end
        default: begin
          // Unreachable (0,1): recover to EMPTY rather than emit a stale skid entry.
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end
      endcase
    end
  end

  // Architectural flags follow every accepted op except NUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags_q <= 4'b0000;
    end else if (w_in_fire && (in_opcode != OP_NUL)) begin
      r_flags_q <= in_flags;
    end
  end

  // Sticky overflow and saturating counter; an overflowing accept beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end else if (w_in_ovf) begin
      r_ovf_sticky <= 1'b1;
      if (sticky_clr) begin
        r_ovf_count <= CNT_ONE;
      end else if (!w_cnt_max) begin
        r_ovf_count <= r_ovf_count + CNT_ONE;
      end
    end else if (sticky_clr) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (counter width 2 to reach saturation quickly).
module tb_alu_result_stage;

  localparam int BW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [BW-1:0] in_result;
  logic [3:0]    in_flags;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_opcode;
  logic [BW-1:0] out_result;
  logic [3:0]    out_flags;
  logic [3:0]    flags_q;
  logic          ovf_sticky;
  logic          sticky_clr;
  logic [CW-1:0] ovf_count;

  int errors = 0;
  int checks = 0;

  alu_result_stage #(.BUS_WIDTH(BW), .OVF_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_result(out_result), .out_flags(out_flags),
    .flags_q(flags_q), .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [BW-1:0] res, input logic [3:0] flg);
    in_valid  = v;
    in_opcode = op;
    in_result = res;
    in_flags  = flg;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 4'h0);
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_flags_q",   64'(flags_q),   64'd0);
    chk("rst_count",     64'(ovf_count), 64'd0);
    rst_n = 1'b1;
    cyc();

    // ADD, result 5, flags 0000
    out_ready = 1'b1;
    drive(1'b1, 4'h1, 32'h0000_0005, 4'b0000);
    cyc();
    chk("add_out_valid",  64'(out_valid),  64'd1);
    chk("add_out_result", 64'(out_result), 64'h5);
    chk("add_out_opcode", 64'(out_opcode), 64'h1);
    chk("add_flags_q",    64'(flags_q),    64'h0);
    drive(1'b0, 4'h0, 32'h0, 4'h0);
    cyc();
    chk("add_drained", 64'(out_valid), 64'd0);

    // SUB with overflow, then NUL with flags 0100
    drive(1'b1, 4'h2, 32'h10, 4'b1000);
    cyc();
    chk("sub_flags_q", 64'(flags_q),    64'b1000);
    chk("sub_sticky",  64'(ovf_sticky), 64'd1);
    chk("sub_count",   64'(ovf_count),  64'd1);
    drive(1'b1, 4'h0, 32'h20, 4'b0100);
    cyc();
    chk("nul_flags_q_held", 64'(flags_q),    64'b1000);
    chk("nul_out_opcode",   64'(out_opcode), 64'h0);
    chk("nul_out_flags",    64'(out_flags),  64'b0100);
    chk("nul_out_result",   64'(out_result), 64'h20);
    drive(1'b0, 4'h0, 32'h0, 4'h0);
    cyc();
    chk("nul_drained", 64'(out_valid), 64'd0);

    // sticky_clr alone
    sticky_clr = 1'b1;
    cyc();
    sticky_clr = 1'b0;
    chk("clr_sticky",  64'(ovf_sticky), 64'd0);
    chk("clr_count",   64'(ovf_count),  64'd0);
    chk("clr_flags_q", 64'(flags_q),    64'b1000);

    // Backpressure: A, B fill the buffer, third push stalls
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 32'h11, 4'b0000);
    cyc();
    chk("bp_a_out",      64'(out_result), 64'h11);
    chk("bp_a_in_ready", 64'(in_ready),   64'd1);
    drive(1'b1, 4'h1, 32'h22, 4'b0000);
    cyc();
    chk("bp_b_in_ready", 64'(in_ready),   64'd0);
    chk("bp_b_out_hold", 64'(out_result), 64'h11);
    drive(1'b1, 4'h1, 32'h33, 4'b0000);
    cyc();
    chk("bp_c_stall",    64'(in_ready),   64'd0);
    chk("bp_c_out_hold", 64'(out_result), 64'h11);
    drive(1'b0, 4'h0, 32'h0, 4'h0);
    out_ready = 1'b1;
    cyc();
    chk("bp_rel_b_valid", 64'(out_valid),  64'd1);
    chk("bp_rel_b",       64'(out_result), 64'h22);
    chk("bp_rel_ready",   64'(in_ready),   64'd1);
    cyc();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // 8 back-to-back bundles with out_ready held high
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'h3, 32'h100 + 32'(i), 4'b0000);
      cyc();
      chk("b2b_valid",  64'(out_valid),  64'd1);
      chk("b2b_result", 64'(out_result), 64'h100 + 64'(i));
    end
    drive(1'b0, 4'h0, 32'h0, 4'h0);
    cyc();
    chk("b2b_drained", 64'(out_valid), 64'd0);

    // Five overflows saturate a 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'h1, 32'h200 + 32'(i), 4'b1000);
      cyc();
      chk("sat_count", 64'(ovf_count), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    chk("sat_sticky", 64'(ovf_sticky), 64'd1);
    // Sixth overflow together with sticky_clr: set wins
    drive(1'b1, 4'h1, 32'h300, 4'b1000);
    sticky_clr = 1'b1;
    cyc();
    sticky_clr = 1'b0;
    chk("setwin_sticky", 64'(ovf_sticky), 64'd1);
    chk("setwin_count",  64'(ovf_count),  64'd1);
    drive(1'b0, 4'h0, 32'h0, 4'h0);
    cyc();

    // Reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 32'h44, 4'b1001);
    cyc();
    drive(1'b1, 4'h1, 32'h55, 4'b1001);
    cyc();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count",    64'(ovf_count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid),  64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),   64'd1);
    chk("mid_rst_flags_q",   64'(flags_q),    64'd0);
    chk("mid_rst_count",     64'(ovf_count),  64'd0);
    chk("mid_rst_sticky",    64'(ovf_sticky), 64'd0);
    cyc();
    chk("in_rst_no_accept", 64'(out_valid), 64'd0);
    drive(1'b0, 4'h0, 32'h0, 4'h0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the directed sequence is short, so any overrun means a hang.
  initial begin
    #20000;
    $display("FAIL watchdog: sequence did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
